// File: rtl/gpu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_arb_pkg
// Description : Shared FSM state enumeration and width helpers for the FWFT
//               FIFO read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_arb_pkg;

    // Arbiter control states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Bits needed to index NUM_SRC sources (never narrower than 1)
    function automatic int idx_width(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

    // Bits needed to count 0..MAX_BURST-1 words within a burst
    function automatic int cnt_width(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rr_pick
// Description : Combinational round-robin picker. Returns the first eligible
//               index searching upward from last_grant+1, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rr_pick
    import gpu_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] eligible,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    // Scan offsets from farthest to nearest so the nearest eligible wins
    always_comb begin
        logic [IDX_W-1:0] w_cand;
        found  = 1'b0;
        index  = '0;
        w_cand = '0;
        for (int off = NUM_SRC; off >= 1; off--) begin
            w_cand = IDX_W'((int'(last_grant) + off) % NUM_SRC);
            if (eligible[w_cand]) begin
                found = 1'b1;
                index = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_arbiter
// Description : Round-robin burst arbiter draining NUM_SRC FWFT FIFOs into a
//               single registered valid/ready output, up to MAX_BURST words
//               per grant, one word per clock at full throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_arbiter
    import gpu_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_empty_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_dout_i,
    output logic [NUM_SRC-1:0]            src_rd_en_o,
    input  logic [NUM_SRC-1:0]            src_enable_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic [idx_width(NUM_SRC)-1:0] out_src_o,
    output logic                          busy_o
);

    localparam int                  IDX_W      = idx_width(NUM_SRC);
    localparam int                  CNT_W      = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0]    C_LAST_CNT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0]    C_LAST_RST = IDX_W'(NUM_SRC - 1);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [IDX_W-1:0]       r_grant;
    logic [IDX_W-1:0]       r_last_grant;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic [IDX_W-1:0]       r_out_src;

    logic [NUM_SRC-1:0]     w_elig;
    logic                   w_found;
    logic [IDX_W-1:0]       w_pick;
    logic                   w_grant_elig;
    logic [DATA_WIDTH-1:0]  w_head;
    logic                   w_slot_free;
    logic                   w_pop;
    logic                   w_start;
    logic                   w_end;

    assign w_elig      = ~src_empty_i & src_enable_i;
    assign w_slot_free = ~r_out_valid | out_ready_i;
    assign w_pop       = (r_state == ST_BURST) & w_grant_elig & w_slot_free;

    fifo_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .eligible   (w_elig),
        .last_grant (r_last_grant),
        .found      (w_found),
        .index      (w_pick)
    );

    // Granted-source mux: head word, eligibility and the pop strobe
    always_comb begin
        w_head       = '0;
        w_grant_elig = 1'b0;
        src_rd_en_o  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant == IDX_W'(i)) begin
                w_head         = src_dout_i[i*DATA_WIDTH +: DATA_WIDTH];
                w_grant_elig   = w_elig[i];
                src_rd_en_o[i] = w_pop;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: start a burst on any eligible source, end it when the
    // granted source drains/disables or the burst limit is reached
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_BURST;
                    w_start     = 1'b1;
                end
            end
            ST_BURST: begin
                if (!w_grant_elig || (w_pop && (r_cnt == C_LAST_CNT))) begin
                    w_state_nxt = ST_IDLE;
                    w_end       = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant, burst counter and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= '0;
            r_cnt        <= '0;
            r_last_grant <= C_LAST_RST;
        end else begin
            if (w_start) begin
                r_grant <= w_pick;
                r_cnt   <= '0;
            end else if (w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_end) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Output register: load on pop, drain on acceptance without a pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_head;
            r_out_src   <= r_grant;
        end else if (r_out_valid && out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_src_o   = r_out_src;
    assign busy_o      = (r_state == ST_BURST);

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_read_arbiter
// Description : Self-checking bench for fifo_read_arbiter. Behavioural FWFT
//               sources feed the DUT; a transaction-level round-robin model
//               predicts the delivered source/word order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_arbiter;

    localparam int NSRC  = 4;
    localparam int DW    = 32;
    localparam int MB    = 8;
    localparam int DEPTH = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NSRC-1:0]   src_empty;
    logic [NSRC*DW-1:0] src_dout;
    logic [NSRC-1:0]   src_rd_en;
    logic [NSRC-1:0]   src_enable = '1;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_src;
    logic              busy;

    logic [DW-1:0]     mem [NSRC][DEPTH];
    int                rd_ptr   [NSRC] = '{default: 0};
    int                wr_ptr   [NSRC] = '{default: 0};
    int                next_seq [NSRC] = '{default: 0};
    int                exp_seq  [NSRC] = '{default: 0};
    int                pop_cnt  [NSRC] = '{default: 0};
    int                rem      [NSRC] = '{default: 0};
    int                exp_q[$];
    int                acc_cyc[$];
    int                cyc        = 0;
    int                model_last = NSRC - 1;
    int                ready_mode = 0;
    int                n_checks   = 0;
    int                n_pass     = 0;

    logic [DW-1:0]     prev_data  = '0;
    logic [1:0]        prev_src   = '0;
    logic              prev_stall = 1'b0;

    fifo_read_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_SRC    (NSRC),
        .MAX_BURST  (MB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_empty_i  (src_empty),
        .src_dout_i   (src_dout),
        .src_rd_en_o  (src_rd_en),
        .src_enable_i (src_enable),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_src_o    (out_src),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FWFT sources
    always_comb begin
        src_dout  = '0;
        src_empty = '1;
        for (int i = 0; i < NSRC; i++) begin
            src_dout[i*DW +: DW] = mem[i][rd_ptr[i] % DEPTH];
            src_empty[i]         = (rd_ptr[i] == wr_ptr[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (src_rd_en[i]) rd_ptr[i] <= rd_ptr[i] + 1;
        end
    end

    // Consumer ready pattern
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       out_ready = ~out_ready;
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic load_src(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            mem[s][wr_ptr[s] % DEPTH] = {8'(s), 24'(next_seq[s])};
            next_seq[s]++;
            wr_ptr[s]++;
        end
    endtask

    // Round-robin bursts of min(MB, remaining) over the preloaded counts
    task automatic model_bursts();
        int left;
        left = 0;
        for (int i = 0; i < NSRC; i++) left += rem[i];
        while (left > 0) begin
            int found;
            found = 0;
            for (int off = 1; off <= NSRC && found == 0; off++) begin
                int s, take;
                s = (model_last + off) % NSRC;
                if (rem[s] > 0) begin
                    take = (rem[s] < MB) ? rem[s] : MB;
                    for (int k = 0; k < take; k++) exp_q.push_back(s);
                    rem[s]    -= take;
                    left      -= take;
                    model_last = s;
                    found      = 1;
                end
            end
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_src", out_src, 0);
        chk("rst_rd_en", src_rd_en, 0);
        chk("rst_busy", busy, 0);
        rst        = 1'b0;
        model_last = NSRC - 1;
        @(posedge clk);
        #1;
    endtask

    // Per-cycle monitor: strobe rules, stall behaviour, delivered order
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_no_pop", src_rd_en, 0);
            prev_stall = 1'b0;
        end else begin
            chk("rd_onehot", ($countones(src_rd_en) <= 1), 1);
            chk("rd_on_empty", src_rd_en & src_empty, 0);
            if (src_rd_en != 0) chk("busy_on_pop", busy, 1);
            for (int i = 0; i < NSRC; i++) if (src_rd_en[i]) pop_cnt[i]++;
            if (prev_stall) begin
                chk("stall_data", out_data, prev_data);
                chk("stall_src", out_src, prev_src);
            end
            if (out_valid && !out_ready) chk("stall_no_pop", src_rd_en, 0);
            if (out_valid && out_ready) begin
                chk("word_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    int s;
                    s = exp_q.pop_front();
                    chk("out_src", out_src, s);
                    chk("out_data", out_data, {8'(s), 24'(exp_seq[s])});
                    exp_seq[s]++;
                end
                acc_cyc.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_src   = out_src;
        end
    end

    initial begin
        int pc, n, left3;

        do_reset();

        // Two sources of 3 words: latency, order and bubble between bursts
        acc_cyc.delete();
        load_src(0, 3);
        load_src(2, 3);
        rem = '{3, 0, 3, 0};
        model_bursts();
        @(posedge clk); #1;
        chk("lat_t1_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_t2_valid", out_valid, 1);
        chk("lat_t2_src", out_src, 0);
        wait_drain(100);
        chk("s1_accepts", acc_cyc.size(), 6);
        if (acc_cyc.size() >= 4) chk("s1_bubble", (acc_cyc[3] - acc_cyc[2] > 1), 1);

        // All four sources with 20 words each
        do_reset();
        for (int i = 0; i < NSRC; i++) load_src(i, 20);
        rem = '{20, 20, 20, 20};
        model_bursts();
        wait_drain(400);
        chk("s2_all_empty", src_empty, 4'hF);

        // Back-pressure with toggling ready
        do_reset();
        ready_mode = 1;
        pc = pop_cnt[1];
        load_src(1, 5);
        rem = '{0, 5, 0, 0};
        model_bursts();
        wait_drain(100);
        chk("s3_pulses", pop_cnt[1] - pc, 5);
        ready_mode = 0;

        // Disable source 1 mid-burst
        do_reset();
        pc = pop_cnt[1];
        load_src(1, 6);
        load_src(2, 3);
        exp_q = '{1, 1, 2, 2, 2, 1, 1, 1, 1};
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while ((pop_cnt[1] - pc) < 2 && n < 50);
        #1 src_enable[1] = 1'b0;
        @(posedge clk); #1;
        chk("s4_idle_after_dis", busy, 0);
        n = 0;
        while (exp_q.size() > 4 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("s4_src1_holds", src_empty[1], 0);
        src_enable[1] = 1'b1;
        wait_drain(100);

        // Asynchronous reset during a burst of source 3
        do_reset();
        pc = pop_cnt[3];
        load_src(3, 10);
        rem = '{0, 0, 0, 10};
        model_bursts();
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while ((pop_cnt[3] - pc) < 3 && n < 50);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_src", out_src, 0);
        chk("arst_rd_en", src_rd_en, 0);
        chk("arst_busy", busy, 0);
        exp_q.delete();
        load_src(0, 4);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_seq[3] = int'(mem[3][rd_ptr[3] % DEPTH][23:0]);
        left3      = wr_ptr[3] - rd_ptr[3];
        model_last = NSRC - 1;
        rem        = '{4, 0, 0, left3};
        model_bursts();
        wait_drain(200);
        chk("s5_all_empty", src_empty, 4'hF);

        // Randomised counts with random back-pressure, no reset in between
        ready_mode = 2;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < NSRC; i++) begin
                rem[i] = $urandom_range(0, 12);
                load_src(i, rem[i]);
            end
            model_bursts();
            wait_drain(600);
            chk("rand_empty", src_empty, 4'hF);
        end
        ready_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_read_arbiter.md
FIFO_READ_ARBITER -- requirements
Module: fifo_read_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every source word and of out_data_o.
REQ-002 Parameter NUM_SRC, default 4, legal range 2..8: number of first-word-fall-through (FWFT) FIFO sources.
REQ-003 Parameter MAX_BURST, default 8, legal range 1..256: maximum consecutive words taken from one source per grant.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 src_empty_i  input  NUM_SRC  per-source FWFT empty flag; bit i high means source i has no word.
REQ-007 src_dout_i  input  NUM_SRC*DATA_WIDTH  per-source head word; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 src_rd_en_o  output  NUM_SRC  per-source pop strobe; at most one bit high per cycle.
REQ-009 src_enable_i  input  NUM_SRC  per-source arbitration enable; quasi-static configuration.
REQ-010 out_valid_o  output  1  output register holds a word.
REQ-011 out_ready_i  input  1  consumer accepts the word this cycle when out_valid_o is also high.
REQ-012 out_data_o  output  DATA_WIDTH  registered word.
REQ-013 out_src_o  output  clog2(NUM_SRC)  index of the source out_data_o came from.
REQ-014 busy_o  output  1  high while the state is BURST.

Function
REQ-015 States: IDLE and BURST; a grant register holds the granted index; a burst counter holds words popped in the current burst.
REQ-016 A source is eligible when src_empty_i[i] is 0 and src_enable_i[i] is 1.
REQ-017 In IDLE, if any source is eligible, the arbiter grants the first eligible index searching upward from last_grant+1, wrapping modulo NUM_SRC; it enters BURST next cycle with the counter at 0.
REQ-018 In IDLE, src_rd_en_o is all zero.
REQ-019 A slot is free when out_valid_o is 0, or when out_valid_o and out_ready_i are both 1.
REQ-020 Pop condition: state is BURST, the granted source is eligible, and the slot is free.
REQ-021 On a pop, src_rd_en_o[grant] is 1 combinationally, and on that same edge out_data_o takes the granted source's head word and out_src_o takes the grant index.
REQ-022 On a pop, out_valid_o is 1 on the next cycle and the burst counter increments.
REQ-023 When the output word is accepted with no pop in the same cycle, out_valid_o falls to 0 on the next cycle.
REQ-024 When acceptance and a pop coincide, out_valid_o stays high with the new word (full throughput, 1 word per clock).
REQ-025 A pop with the counter at MAX_BURST-1 ends the burst: return to IDLE, last_grant takes the grant index.
REQ-026 In BURST, if the granted source is not eligible (empty or disabled), return to IDLE next cycle with no pop; last_grant takes the grant index.
REQ-027 An ineligible granted source with a non-free slot in the same cycle follows REQ-026.
REQ-028 Latency: a source eligible in IDLE at cycle t is popped at the earliest at t+1, and its word is on out_data_o with out_valid_o high at t+2.
REQ-029 There is exactly one IDLE cycle between consecutive bursts.
REQ-030 If out_ready_i stays low, the arbiter holds the output word and pops nothing; the burst counter does not change.
REQ-031 Word order from each source is preserved, and no word is duplicated or dropped.
REQ-032 Changes to src_enable_i affect only future arbitration decisions and the REQ-026 check; a word already in the output register is still delivered.

Reset
REQ-033 While rst is high: state=IDLE, burst counter=0, last_grant=NUM_SRC-1 (so source 0 has first priority), out_valid_o=0, out_data_o=0, out_src_o=0, src_rd_en_o=0.
REQ-034 Reset asserted mid-burst discards the output register contents; no source is popped while rst is high.

Structure
REQ-035 A shared package (gpu_arb_pkg) holds the state enumeration and the index/counter width functions derived from NUM_SRC and MAX_BURST.
REQ-036 One combinational sub-module, fifo_rr_pick, computes the round-robin choice from the eligible mask and last_grant and returns a found flag and an index.
REQ-037 fifo_read_arbiter contains all sequential logic; the datapath mux from src_dout_i is inside fifo_read_arbiter.

Verification
REQ-038 After reset, sources 0 and 2 each hold 3 words, out_ready_i=1, MAX_BURST=8 -> out_src_o sequence 0,0,0,2,2,2 with one bubble between the two bursts; the first valid word appears 2 cycles after the first eligible cycle.
REQ-039 All 4 sources hold 20 words, MAX_BURST=8 -> bursts of 8 from sources 0,1,2,3, then 0,1,2,3 again, then 4 from each; 80 words total, in order per source.
REQ-040 Source 1 holds 5 words, out_ready_i toggles 1,0,1,0 -> no pop and no data change while out_valid_o=1 and out_ready_i=0; the 5 words arrive intact; src_rd_en_o[1] pulses exactly 5 times.
REQ-041 src_enable_i[1] is cleared mid-burst on source 1 -> the word in flight is delivered, the next cycle returns to IDLE, and source 2 is granted next while source 1 still holds data.
REQ-042 rst is asserted asynchronously between clock edges during a burst of source 3 -> outputs clear immediately; after release, source 0 (if eligible) is granted first and no source is popped while in reset.
REQ-043 Assertion checks: at most one bit of src_rd_en_o is high in any cycle, and no bit of src_rd_en_o is high when its src_empty_i bit is high.
